// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: captures decoded state,
// forwards MEM/WB results into the ALU operands and detects load-use hazards.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid_i,
  input  logic [DATA_W-1:0]  id_rs_data_i,
  input  logic [DATA_W-1:0]  id_rt_data_i,
  input  logic [DATA_W-1:0]  id_imm_i,
  input  logic [RADDR_W-1:0] id_rs_i,
  input  logic [RADDR_W-1:0] id_rt_i,
  input  logic [RADDR_W-1:0] id_rd_i,
  input  logic [3:0]         id_alu_control_i,
  input  logic               id_alu_src_i,
  input  logic               id_reg_dst_i,
  input  logic               id_reg_write_i,
  input  logic               id_mem_read_i,
  input  logic               id_mem_write_i,
  input  logic               id_mem_to_reg_i,
  input  logic               flush_i,
  input  logic               mem_reg_write_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic [DATA_W-1:0]  mem_result_i,
  input  logic               wb_reg_write_i,
  input  logic [RADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0]  wb_data_i,
  output logic [DATA_W-1:0]  op1_o,
  output logic [DATA_W-1:0]  op2_o,
  output logic [3:0]         alu_control_o,
  output logic [DATA_W-1:0]  ex_rt_data_o,
  output logic [RADDR_W-1:0] ex_dest_o,
  output logic               ex_valid_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic               ex_mem_write_o,
  output logic               ex_mem_to_reg_o,
  output logic               stall_o
);

  logic               valid_r;
  logic               reg_write_r;
  logic               mem_read_r;
  logic               mem_write_r;
  logic               mem_to_reg_r;
  logic               alu_src_r;
  logic [3:0]         alu_control_r;
  logic [DATA_W-1:0]  rs_data_r;
  logic [DATA_W-1:0]  rt_data_r;
  logic [DATA_W-1:0]  imm_r;
  logic [RADDR_W-1:0] rs_r;
  logic [RADDR_W-1:0] rt_r;
  logic [RADDR_W-1:0] dest_r;

  logic               stall_s;
  logic               bubble_s;
  logic [DATA_W-1:0]  rs_fwd_s;
  logic [DATA_W-1:0]  rt_fwd_s;

  // MEM has priority over WB; $0 is hard-wired zero and never bypassed.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [RADDR_W-1:0] src,
    input logic [DATA_W-1:0]  reg_val,
    input logic               m_we,
    input logic [RADDR_W-1:0] m_rd,
    input logic [DATA_W-1:0]  m_val,
    input logic               w_we,
    input logic [RADDR_W-1:0] w_rd,
    input logic [DATA_W-1:0]  w_val
  );
    logic [DATA_W-1:0] res;
    if (m_we && (m_rd != {RADDR_W{1'b0}}) && (m_rd == src)) begin
      res = m_val;
    end else if (w_we && (w_rd != {RADDR_W{1'b0}}) && (w_rd == src)) begin
      res = w_val;
    end else begin
      res = reg_val;
    end
    return res;
  endfunction

  // Load-use hazard detection; a flush in decode wins over the stall
  always_comb begin
    stall_s = 1'b0;
    if (!flush_i && id_valid_i && valid_r && mem_read_r &&
        (dest_r != {RADDR_W{1'b0}}) && ((dest_r == id_rs_i) || (dest_r == id_rt_i))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign bubble_s = flush_i | stall_s | ~id_valid_i;

  // Control register: cleared on reset and on any bubble
  always_ff @(posedge clk) begin
    if (rst || bubble_s) begin
      valid_r       <= 1'b0;
      reg_write_r   <= 1'b0;
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_to_reg_r  <= 1'b0;
      alu_src_r     <= 1'b0;
      alu_control_r <= 4'b0000;
    end else begin
      valid_r       <= 1'b1;
      reg_write_r   <= id_reg_write_i;
      mem_read_r    <= id_mem_read_i;
      mem_write_r   <= id_mem_write_i;
      mem_to_reg_r  <= id_mem_to_reg_i;
      alu_src_r     <= id_alu_src_i;
      alu_control_r <= id_alu_control_i;
    end
  end

  // Data register: contents of a bubble are don't-care, so load every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_data_r <= {DATA_W{1'b0}};
      rt_data_r <= {DATA_W{1'b0}};
      imm_r     <= {DATA_W{1'b0}};
      rs_r      <= {RADDR_W{1'b0}};
      rt_r      <= {RADDR_W{1'b0}};
      dest_r    <= {RADDR_W{1'b0}};
    end else begin
      rs_data_r <= id_rs_data_i;
      rt_data_r <= id_rt_data_i;
      imm_r     <= id_imm_i;
      rs_r      <= id_rs_i;
      rt_r      <= id_rt_i;
      dest_r    <= id_reg_dst_i ? id_rd_i : id_rt_i;
    end
  end

  // Operand forwarding muxes for rs and rt
  always_comb begin
    rs_fwd_s = fwd_sel(rs_r, rs_data_r, mem_reg_write_i, mem_rd_i, mem_result_i,
                       wb_reg_write_i, wb_rd_i, wb_data_i);
    rt_fwd_s = fwd_sel(rt_r, rt_data_r, mem_reg_write_i, mem_rd_i, mem_result_i,
                       wb_reg_write_i, wb_rd_i, wb_data_i);
  end

  // ALU operand 2 selects the immediate regardless of any rt forward
  always_comb begin
    op2_o = rt_fwd_s;
    if (alu_src_r) begin
      op2_o = imm_r;
    end else begin
      op2_o = rt_fwd_s;
    end
  end

  assign op1_o           = rs_fwd_s;
  assign ex_rt_data_o    = rt_fwd_s;
  assign alu_control_o   = alu_control_r;
  assign ex_dest_o       = dest_r;
  assign ex_valid_o      = valid_r;
  assign ex_reg_write_o  = reg_write_r;
  assign ex_mem_read_o   = mem_read_r;
  assign ex_mem_write_o  = mem_write_r;
  assign ex_mem_to_reg_o = mem_to_reg_r;
  assign stall_o         = stall_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model of the EX slot predicts
// each cycle's outputs; a negedge monitor pops and compares them.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid_i, flush_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic [3:0]  id_alu_control_i;
  logic id_alu_src_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
  logic mem_reg_write_i, wb_reg_write_i;
  logic [4:0]  mem_rd_i, wb_rd_i;
  logic [31:0] mem_result_i, wb_data_i;
  logic [31:0] op1_o, op2_o, ex_rt_data_o;
  logic [3:0]  alu_control_o;
  logic [4:0]  ex_dest_o;
  logic ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, stall_o;

  id_ex_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_alu_control_i(id_alu_control_i), .id_alu_src_i(id_alu_src_i),
    .id_reg_dst_i(id_reg_dst_i), .id_reg_write_i(id_reg_write_i),
    .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_mem_to_reg_i(id_mem_to_reg_i), .flush_i(flush_i),
    .mem_reg_write_i(mem_reg_write_i), .mem_rd_i(mem_rd_i), .mem_result_i(mem_result_i),
    .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .op1_o(op1_o), .op2_o(op2_o), .alu_control_o(alu_control_o),
    .ex_rt_data_o(ex_rt_data_o), .ex_dest_o(ex_dest_o), .ex_valid_o(ex_valid_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o), .stall_o(stall_o)
  );

  typedef struct {
    logic rst, valid, flush;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0] rs, rt, rd;
    logic [3:0] aluc;
    logic alu_src, reg_dst, regw, memr, memw, m2r;
    logic mem_regw; logic [4:0] mem_rd; logic [31:0] mem_result;
    logic wb_regw;  logic [4:0] wb_rd;  logic [31:0] wb_data;
  } stim_t;

  // Instruction sitting in EX, as the model sees it
  typedef struct {
    logic known, valid, regw, memr, memw, m2r, alu_src;
    logic [3:0] aluc;
    logic [4:0] rs, rt, dest;
    logic [31:0] rs_data, rt_data, imm;
  } ex_t;

  typedef struct {
    logic known, stall, valid, regw, memr, memw, m2r;
    logic [3:0] aluc;
    logic [4:0] dest;
    logic [31:0] op1, op2, rt_fwd;
  } exp_t;

  ex_t  ex_m, ex_next;
  exp_t exp_q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.valid = 1'b0; s.flush = 1'b0;
    s.rs_data = 32'd0; s.rt_data = 32'd0; s.imm = 32'd0;
    s.rs = 5'd0; s.rt = 5'd0; s.rd = 5'd0; s.aluc = 4'd0;
    s.alu_src = 1'b0; s.reg_dst = 1'b0; s.regw = 1'b0; s.memr = 1'b0; s.memw = 1'b0; s.m2r = 1'b0;
    s.mem_regw = 1'b0; s.mem_rd = 5'd0; s.mem_result = 32'd0;
    s.wb_regw = 1'b0; s.wb_rd = 5'd0; s.wb_data = 32'd0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    logic [3:0] ops [6];
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b1100;
    s.rst = ($urandom_range(0, 49) == 0);
    s.valid = ($urandom_range(0, 9) < 8);
    s.flush = ($urandom_range(0, 9) == 0);
    s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
    s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7)); s.rd = 5'($urandom_range(0, 7));
    s.aluc = ops[$urandom_range(0, 5)];
    s.alu_src = 1'($urandom); s.reg_dst = 1'($urandom); s.regw = 1'($urandom);
    s.memr = ($urandom_range(0, 9) < 4); s.memw = 1'($urandom); s.m2r = 1'($urandom);
    s.mem_regw = 1'($urandom); s.mem_rd = 5'($urandom_range(0, 7)); s.mem_result = $urandom;
    s.wb_regw = 1'($urandom);  s.wb_rd = 5'($urandom_range(0, 7));  s.wb_data = $urandom;
    return s;
  endfunction

  function automatic ex_t zero_ex();
    ex_t e;
    e.known = 1'b1; e.valid = 1'b0; e.regw = 1'b0; e.memr = 1'b0; e.memw = 1'b0; e.m2r = 1'b0;
    e.alu_src = 1'b0; e.aluc = 4'd0; e.rs = 5'd0; e.rt = 5'd0; e.dest = 5'd0;
    e.rs_data = 32'd0; e.rt_data = 32'd0; e.imm = 32'd0;
    return e;
  endfunction

  // Architectural bypass rule: newest producer wins, $0 is never bypassed
  function automatic logic [31:0] fwd(logic [4:0] idx, logic [31:0] v, stim_t s);
    if (s.mem_regw && s.mem_rd != 5'd0 && s.mem_rd == idx) return s.mem_result;
    if (s.wb_regw && s.wb_rd != 5'd0 && s.wb_rd == idx) return s.wb_data;
    return v;
  endfunction

  task automatic drive(stim_t s);
    rst = s.rst; id_valid_i = s.valid; flush_i = s.flush;
    id_rs_data_i = s.rs_data; id_rt_data_i = s.rt_data; id_imm_i = s.imm;
    id_rs_i = s.rs; id_rt_i = s.rt; id_rd_i = s.rd; id_alu_control_i = s.aluc;
    id_alu_src_i = s.alu_src; id_reg_dst_i = s.reg_dst; id_reg_write_i = s.regw;
    id_mem_read_i = s.memr; id_mem_write_i = s.memw; id_mem_to_reg_i = s.m2r;
    mem_reg_write_i = s.mem_regw; mem_rd_i = s.mem_rd; mem_result_i = s.mem_result;
    wb_reg_write_i = s.wb_regw; wb_rd_i = s.wb_rd; wb_data_i = s.wb_data;
  endtask

  task automatic cycle(stim_t s);
    exp_t e;
    logic hz;
    @(posedge clk);
    ex_m = ex_next;
    #1;
    drive(s);
    hz = !s.flush && s.valid && ex_m.valid && ex_m.memr && ex_m.dest != 5'd0 &&
         (ex_m.dest == s.rs || ex_m.dest == s.rt);
    e.known = ex_m.known; e.stall = hz; e.valid = ex_m.valid; e.regw = ex_m.regw;
    e.memr = ex_m.memr; e.memw = ex_m.memw; e.m2r = ex_m.m2r; e.aluc = ex_m.aluc;
    e.dest = ex_m.dest;
    e.op1 = fwd(ex_m.rs, ex_m.rs_data, s);
    e.rt_fwd = fwd(ex_m.rt, ex_m.rt_data, s);
    e.op2 = ex_m.alu_src ? ex_m.imm : e.rt_fwd;
    exp_q.push_back(e);
    if (s.rst) begin
      ex_next = zero_ex();
    end else if (s.flush || hz || !s.valid) begin
      ex_next = ex_m;
      ex_next.known = 1'b0; ex_next.valid = 1'b0; ex_next.regw = 1'b0;
      ex_next.memr = 1'b0; ex_next.memw = 1'b0; ex_next.m2r = 1'b0;
    end else begin
      ex_next.known = 1'b1; ex_next.valid = 1'b1; ex_next.regw = s.regw;
      ex_next.memr = s.memr; ex_next.memw = s.memw; ex_next.m2r = s.m2r;
      ex_next.alu_src = s.alu_src; ex_next.aluc = s.aluc;
      ex_next.rs = s.rs; ex_next.rt = s.rt; ex_next.dest = s.reg_dst ? s.rd : s.rt;
      ex_next.rs_data = s.rs_data; ex_next.rt_data = s.rt_data; ex_next.imm = s.imm;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every presented cycle against the oldest prediction
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        me = exp_q.pop_front();
        chk("stall", {31'd0, stall_o}, {31'd0, me.stall});
        chk("ex_valid", {31'd0, ex_valid_o}, {31'd0, me.valid});
        chk("ex_reg_write", {31'd0, ex_reg_write_o}, {31'd0, me.regw});
        chk("ex_mem_read", {31'd0, ex_mem_read_o}, {31'd0, me.memr});
        chk("ex_mem_write", {31'd0, ex_mem_write_o}, {31'd0, me.memw});
        chk("ex_mem_to_reg", {31'd0, ex_mem_to_reg_o}, {31'd0, me.m2r});
        if (me.known) begin
          chk("op1", op1_o, me.op1);
          chk("op2", op2_o, me.op2);
          chk("ex_rt_data", ex_rt_data_o, me.rt_fwd);
          chk("alu_control", {28'd0, alu_control_o}, {28'd0, me.aluc});
          chk("ex_dest", {27'd0, ex_dest_o}, {27'd0, me.dest});
        end
      end
    end
  end

  initial begin
    stim_t s, f, lw, ad, im;
    s = rnd(); s.rst = 1'b1;
    drive(s);
    ex_next = zero_ex();
    s = rnd(); s.rst = 1'b1;
    cycle(s);                               // reset state, random inputs

    s = idle(); s.valid = 1'b1; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd8; s.reg_dst = 1'b1;
    s.regw = 1'b1; s.rs_data = 32'd5; s.rt_data = 32'd7; s.aluc = 4'b0010;
    cycle(s);                               // reset outputs with enables low, issue ADD

    f = idle(); f.valid = 1'b1; f.rs = 5'd3; f.rd = 5'd9; f.reg_dst = 1'b1; f.regw = 1'b1;
    f.rs_data = 32'h11; f.aluc = 4'b0010;
    cycle(f);                               // ADD pass-through visible
    s = f; s.mem_regw = 1'b1; s.mem_rd = 5'd3; s.mem_result = 32'hAA;
    s.wb_regw = 1'b1; s.wb_rd = 5'd3; s.wb_data = 32'hBB;
    cycle(s);                               // MEM beats WB
    s.mem_regw = 1'b0;
    cycle(s);                               // WB only
    s.mem_regw = 1'b1; s.mem_rd = 5'd0; s.wb_rd = 5'd0;
    cycle(s);                               // $0 never forwarded

    lw = idle(); lw.valid = 1'b1; lw.rs = 5'd1; lw.rt = 5'd4; lw.memr = 1'b1; lw.regw = 1'b1;
    lw.m2r = 1'b1; lw.alu_src = 1'b1; lw.imm = 32'd8; lw.rs_data = 32'd100; lw.aluc = 4'b0010;
    ad = idle(); ad.valid = 1'b1; ad.rs = 5'd4; ad.rt = 5'd5; ad.rd = 5'd6; ad.reg_dst = 1'b1;
    ad.regw = 1'b1; ad.rt_data = 32'd3; ad.aluc = 4'b0010;
    cycle(lw);
    cycle(ad);                              // load-use stall
    cycle(ad);                              // bubble in EX, stall drops
    s = idle(); s.wb_regw = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'h1234;
    cycle(s);                               // add in EX, rs from WB

    cycle(lw);
    s = ad; s.flush = 1'b1;
    cycle(s);                               // flush suppresses stall
    cycle(idle());                          // bubble captured

    cycle(lw);
    s = ad; s.rst = 1'b1;
    cycle(s);                               // reset during stall
    cycle(ad);                              // cleared, no stall

    im = idle(); im.valid = 1'b1; im.rs = 5'd2; im.rt = 5'd6; im.alu_src = 1'b1;
    im.imm = 32'hFFFFFFFC; im.rs_data = 32'd2; im.rt_data = 32'd1; im.aluc = 4'b0010; im.regw = 1'b1;
    cycle(im);
    s = idle(); s.mem_regw = 1'b1; s.mem_rd = 5'd6; s.mem_result = 32'd9;
    cycle(s);                               // imm selected, rt still forwarded

    s = lw; s.rt = 5'd0;
    cycle(s);
    s = ad; s.rs = 5'd0;
    cycle(s);                               // load to $0 never stalls

    repeat (400) cycle(rnd());
    cycle(idle());
    @(negedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection for the 5-stage MIPS core. It captures decoded operands and control from the decode stage, then drives the ALU's `op1_i`, `op2_i` and `alu_control` inputs through forwarding muxes that bypass results from the MEM and WB stages. It also raises a one-cycle load-use stall toward the fetch and decode stages, and inserts bubbles on stall or flush.

## Interface
- `DATA_W`, 32, datapath width
- `RADDR_W`, 5, register index width

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `id_valid_i`  in  1  decode stage holds a real instruction
- `id_rs_data_i`, `id_rt_data_i`  in  DATA_W  register file read data
- `id_imm_i`  in  DATA_W  sign-extended immediate
- `id_rs_i`, `id_rt_i`, `id_rd_i`  in  RADDR_W  register indices
- `id_alu_control_i`  in  4  ALU operation code: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
- `id_alu_src_i`, `id_reg_dst_i`, `id_reg_write_i`, `id_mem_read_i`, `id_mem_write_i`, `id_mem_to_reg_i`  in  1  decoded control bits
- `flush_i`  in  1  squash the instruction in decode (taken branch or jump)
- `mem_reg_write_i`  in  1  MEM-stage instruction writes a register
- `mem_rd_i`  in  RADDR_W  MEM-stage destination register
- `mem_result_i`  in  DATA_W  MEM-stage ALU result
- `wb_reg_write_i`  in  1  WB-stage instruction writes a register
- `wb_rd_i`  in  RADDR_W  WB-stage destination register
- `wb_data_i`  in  DATA_W  WB-stage write data
- `op1_o`, `op2_o`  out  DATA_W  ALU operands
- `alu_control_o`  out  4  ALU operation code
- `ex_rt_data_o`  out  DATA_W  forwarded rt value, used as store data
- `ex_dest_o`  out  RADDR_W  EX-stage destination register
- `ex_valid_o`, `ex_reg_write_o`, `ex_mem_read_o`, `ex_mem_write_o`, `ex_mem_to_reg_o`  out  1  registered control outputs
- `stall_o`  out  1  load-use hazard; fetch and decode hold their registers this cycle

## Operation
- **Capture.** Each rising edge captures decode state, in priority order `rst` > `flush_i` > `stall_o` > normal load.
- **Reset.** Clears every register to 0: valid, all control bits, data, indices, `alu_control`.
- **Bubble.** Taken on `flush_i` or `stall_o`. Valid and all control bits are cleared to 0; data fields are don't-care.
- **Normal load.**
  - All fields are captured from the `id_*` inputs.
  - `ex_dest` captures `id_reg_dst_i ? id_rd_i : id_rt_i`.
  - `id_valid_i = 0` captures a bubble.
- **Stall.** Defined as `stall_o = !flush_i & id_valid_i & ex_valid & ex_mem_read & (ex_dest != 0) & (ex_dest == id_rs_i | ex_dest == id_rt_i)`.
  - This produces exactly one bubble, because the following cycle holds a non-load in EX.
- **Forwarding.** Applied per source, rs and rt, using the registered indices:
  - If `mem_reg_write_i & mem_rd_i != 0 & mem_rd_i == src`, the operand is `mem_result_i`.
  - Else if `wb_reg_write_i & wb_rd_i != 0 & wb_rd_i == src`, the operand is `wb_data_i`.
  - Else the operand is the registered register-file data.
  - MEM beats WB. Register $0 is never forwarded.
- **Outputs.**
  - `op1_o` = forwarded rs.
  - `op2_o` = `alu_src ? imm : forwarded rt`.
  - `ex_rt_data_o` = forwarded rt.
- **Register file.** The register file is write-before-read, so this block never bypasses into ID.

## Timing
- Control and data have 1-cycle latency from the `id_*` inputs to the registered outputs.
- The forwarding muxes, `op1_o`, `op2_o`, `ex_rt_data_o` and `stall_o` are combinational within the same cycle. They have no dependence on `op*` outputs, so there is no combinational loop.
- **Reset values.** All registered outputs are 0. `op1_o`, `op2_o` and `ex_rt_data_o` are 0 while MEM and WB write enables are low.
- **Simultaneous `flush_i` and a load-use condition.** `stall_o = 0` and a bubble is captured.
- **`rst` during a stall.** The stage clears. `stall_o` drops next cycle because `ex_valid = 0`.
- **MEM and WB target the same register.** The MEM value is used.
- **Load in EX writing $0.** No stall.
- **`op2_o` with `alu_src = 1`.** The immediate is selected even if rt matches a forwarding source; `ex_rt_data_o` still forwards.

## Test plan
1. **Reset.** Assert `rst` for 2 cycles with all inputs random -> all registered outputs 0; `stall_o` = 0.
2. **Pass-through.** ADD with rs data 5, rt data 7, `alu_control` 0010, `alu_src` 0 -> one cycle later `op1_o` = 5, `op2_o` = 7, `alu_control_o` = 0010, `ex_valid_o` = 1.
3. **Forwarding priority.**
   - With EX rs = 3, set `mem_reg_write_i` = 1, `mem_rd_i` = 3, `mem_result_i` = 0xAA, and `wb_rd_i` = 3, `wb_data_i` = 0xBB -> `op1_o` = 0xAA.
   - Then drop MEM -> `op1_o` = 0xBB.
   - Then set `mem_rd_i` = 0 -> no forward.
4. **Load-use.** `lw $4` in EX, `add` reading `$4` in ID -> `stall_o` = 1 for exactly 1 cycle. EX captures a bubble (`ex_reg_write_o` = 0). The add enters EX on the following edge, and `op1_o` comes from WB or MEM forwarding.
5. **Flush over stall.** Load-use condition plus `flush_i` = 1 -> `stall_o` = 0; next cycle `ex_valid_o` = 0 and `ex_mem_write_o` = 0.
6. **Immediate select.** `alu_src` = 1, imm = 0xFFFFFFFC, rt forwarded from MEM = 9 -> `op2_o` = 0xFFFFFFFC, `ex_rt_data_o` = 9.
